// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg
//   Shared definitions for the GPR writeback arbiter slice:
//   register file geometry and the arbiter's requester IDs.
package gpr_wb_arbiter_pkg;

    localparam int unsigned GPR_WIDTH          = 32;
    localparam int unsigned GRP_ADDR_WIDTH     = 4;
    localparam int unsigned REGISTER_FILE_SIZE = 16;

    // Requester IDs; also the encoding of the last_grant register.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational 2-way round-robin picker.
//   Ports:
//     valid_i      [1:0]  request valid per requester
//     last_grant_i        requester granted most recently
//     grant_o      [1:0]  one-hot grant (all zero when nothing is valid)
module rr_arb2
    import gpr_wb_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_e    last_grant_i,
    output logic [1:0] grant_o
);

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant_o    = '0;
        grant_o[0] = valid_i[0] & (~valid_i[1] | (last_grant_i == REQ_MEM));
        grant_o[1] = valid_i[1] & (~valid_i[0] | (last_grant_i == REQ_ALU));
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Shares the GPR file's single write port between the ALU writeback
//   (requester 0) and the load writeback (requester 1). Round-robin grant,
//   valid/ready handshake, one registered writeback stage driving rf_*.
//   In-flight hit flags and forwarded data let decode bypass or stall.
//   Optional build macro: LAPIDO_R0_ZERO_EN (writes to r0 are consumed but
//   never reach the register file; hits on address 0 are suppressed).
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     req0_valid/rd/data/ready ALU writeback handshake
//     req1_valid/rd/data/ready load writeback handshake
//     hold                     pipeline freeze: no write, no new grant
//     rf_en/rf_rd/rf_data      register file write port
//     chk_rs/chk_rt            decode source addresses
//     rs_hit/rt_hit            pending write targets chk_rs/chk_rt
//     fwd_data                 data of the pending write
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = GRP_ADDR_WIDTH,
    parameter int unsigned DATA_W = GPR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
    output logic              rf_en,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] chk_rs,
    input  logic [ADDR_W-1:0] chk_rt,
    output logic              rs_hit,
    output logic              rt_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_rd_q,    wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    req_id_e           last_grant_q, last_grant_d;

    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              sel_writes;
    logic              rs_chk_ok, rt_chk_ok;

    rr_arb2 u_rr_arb2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign sel_rd   = grant[1] ? req1_rd   : req0_rd;
    assign sel_data = grant[1] ? req1_data : req0_data;

`ifdef LAPIDO_R0_ZERO_EN
    assign sel_writes = (sel_rd != '0);
    assign rs_chk_ok  = (chk_rs != '0);
    assign rt_chk_ok  = (chk_rt != '0);
`else
    assign sel_writes = 1'b1;
    assign rs_chk_ok  = 1'b1;
    assign rt_chk_ok  = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            last_grant_q <= REQ_MEM;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: the register file always accepts, so the stage drains
    // on every non-hold cycle and can be refilled in the same cycle.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        last_grant_d = last_grant_q;
        if (!hold) begin
            wb_valid_d = 1'b0;
            if (|grant) begin
                wb_valid_d   = sel_writes;
                wb_rd_d      = sel_rd;
                wb_data_d    = sel_data;
                last_grant_d = grant[1] ? REQ_MEM : REQ_ALU;
            end
        end
    end

    // Outputs. Ready is also masked by rst so nothing is reported as
    // accepted while the stage is being cleared.
    always_comb begin
        req0_ready = grant[0] & ~hold & ~rst;
        req1_ready = grant[1] & ~hold & ~rst;
        rf_en      = wb_valid_q & ~hold;
        rf_rd      = wb_rd_q;
        rf_data    = wb_data_q;
        fwd_data   = wb_data_q;
        rs_hit     = wb_valid_q & (wb_rd_q == chk_rs) & rs_chk_ok;
        rt_hit     = wb_valid_q & (wb_rd_q == chk_rt) & rt_chk_ok;
    end

endmodule
